// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, plus the prediction
// registers that travel with the instruction through IF/ID, ID/EX and EX/MEM.
module branch_predictor #(
  parameter int W       = 32,
  parameter int ENTRIES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] if_pc,
  input  logic         pc_flush,
  input  logic         id_stall,
  input  logic         id_ex_bubble,
  input  logic         upd,
  input  logic         add_else_minus,
  input  logic [W-1:0] upd_src_pc,
  input  logic [W-1:0] upd_target,
  output logic         if_pred_taken,
  output logic [W-1:0] if_pred_addr,
  output logic         idex_pred_taken,
  output logic [W-1:0] idex_pred_addr,
  output logic         exmem_pred_taken,
  output logic [W-1:0] exmem_pred_addr
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = W - IDX - 2;

  logic          r_valid  [ENTRIES];
  logic [TW-1:0] r_tag    [ENTRIES];
  logic [W-1:0]  r_target [ENTRIES];
  logic [1:0]    r_ctr    [ENTRIES];

  logic         r_ifid_taken;
  logic [W-1:0] r_ifid_addr;
  logic         r_idex_taken;
  logic [W-1:0] r_idex_addr;
  logic         r_exmem_taken;
  logic [W-1:0] r_exmem_addr;

  logic [IDX-1:0] w_lk_idx;
  logic [TW-1:0]  w_lk_tag;
  logic           w_lk_hit;
  logic [IDX-1:0] w_up_idx;
  logic [TW-1:0]  w_up_tag;
  logic           w_up_hit;

  // Lookup reads the registered BTB, so an update lands for the next cycle.
  assign w_lk_idx = if_pc[IDX+1:2];
  assign w_lk_tag = if_pc[W-1:IDX+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign if_pred_taken = w_lk_hit && r_ctr[w_lk_idx][1];
  assign if_pred_addr  = if_pred_taken ? r_target[w_lk_idx] : (if_pc + W'(4));

  assign w_up_idx = upd_src_pc[IDX+1:2];
  assign w_up_tag = upd_src_pc[W-1:IDX+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b00;
      end
    end else if (upd) begin
      if (w_up_hit) begin
        if (add_else_minus) begin
          if (r_ctr[w_up_idx] != 2'b11) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'b01;
          r_target[w_up_idx] <= upd_target;
        end else if (r_ctr[w_up_idx] != 2'b00) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'b01;
        end
      end else if (add_else_minus) begin
        // New entries start weakly taken; a not-taken miss never allocates.
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= upd_target;
        r_ctr[w_up_idx]    <= 2'b10;
      end
    end
  end

  // ID/EX keeps loading from IF/ID during a stall so the bubble moves down.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_taken  <= 1'b0;
      r_ifid_addr   <= '0;
      r_idex_taken  <= 1'b0;
      r_idex_addr   <= '0;
      r_exmem_taken <= 1'b0;
      r_exmem_addr  <= '0;
    end else begin
      if (pc_flush) begin
        r_ifid_taken <= 1'b0;
        r_ifid_addr  <= '0;
      end else if (!id_stall) begin
        r_ifid_taken <= if_pred_taken;
        r_ifid_addr  <= if_pred_addr;
      end
      if (id_ex_bubble) begin
        r_idex_taken <= 1'b0;
        r_idex_addr  <= '0;
      end else begin
        r_idex_taken <= r_ifid_taken;
        r_idex_addr  <= r_ifid_addr;
      end
      r_exmem_taken <= r_idex_taken;
      r_exmem_addr  <= r_idex_addr;
    end
  end

  assign idex_pred_taken  = r_idex_taken;
  assign idex_pred_addr   = r_idex_addr;
  assign exmem_pred_taken = r_exmem_taken;
  assign exmem_pred_addr  = r_exmem_addr;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: BTB lookup/update, counter saturation,
// aliasing, pipeline stall/flush/bubble and reset override.
module tb_branch_predictor;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] if_pc;
  logic         pc_flush;
  logic         id_stall;
  logic         id_ex_bubble;
  logic         upd;
  logic         add_else_minus;
  logic [W-1:0] upd_src_pc;
  logic [W-1:0] upd_target;
  logic         if_pred_taken;
  logic [W-1:0] if_pred_addr;
  logic         idex_pred_taken;
  logic [W-1:0] idex_pred_addr;
  logic         exmem_pred_taken;
  logic [W-1:0] exmem_pred_addr;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.W(W), .ENTRIES(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .pc_flush         (pc_flush),
    .id_stall         (id_stall),
    .id_ex_bubble     (id_ex_bubble),
    .upd              (upd),
    .add_else_minus   (add_else_minus),
    .upd_src_pc       (upd_src_pc),
    .upd_target       (upd_target),
    .if_pred_taken    (if_pred_taken),
    .if_pred_addr     (if_pred_addr),
    .idex_pred_taken  (idex_pred_taken),
    .idex_pred_addr   (idex_pred_addr),
    .exmem_pred_taken (exmem_pred_taken),
    .exmem_pred_addr  (exmem_pred_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One update strobe for a single edge, then the bench settles past it.
  task automatic upd_step(input logic [W-1:0] pc, input logic taken, input logic [W-1:0] tgt);
    upd = 1'b1;
    add_else_minus = taken;
    upd_src_pc = pc;
    upd_target = tgt;
    tick();
    upd = 1'b0;
    #1;
  endtask

  task automatic chk_pred(input string tag, input logic [W-1:0] pc, input logic exp_t,
                          input logic [W-1:0] exp_a);
    if_pc = pc;
    #1;
    chk({tag, "_t"}, W'(if_pred_taken), W'(exp_t));
    chk({tag, "_a"}, if_pred_addr, exp_a);
  endtask

  initial begin
    rst = 1'b1; pc_flush = 1'b0; id_stall = 1'b0; id_ex_bubble = 1'b0;
    upd = 1'b0; add_else_minus = 1'b0; upd_src_pc = '0; upd_target = '0;
    if_pc = 32'h100;
    tick(); tick();

    chk_pred("rst_lookup", 32'h100, 1'b0, 32'h104);
    chk("rst_idex_t", W'(idex_pred_taken), '0);
    chk("rst_idex_a", idex_pred_addr, '0);
    chk("rst_exmem_t", W'(exmem_pred_taken), '0);
    chk("rst_exmem_a", exmem_pred_addr, '0);
    rst = 1'b0;

    // Allocation becomes visible one cycle later, then walks the pipeline.
    upd = 1'b1; add_else_minus = 1'b1; upd_src_pc = 32'h100; upd_target = 32'h200;
    #1;
    chk("same_cycle_t", W'(if_pred_taken), '0);
    chk("same_cycle_a", if_pred_addr, 32'h104);
    tick();
    upd = 1'b0;
    chk_pred("alloc", 32'h100, 1'b1, 32'h200);
    tick();
    chk("idex_lat_old", idex_pred_addr, 32'h104);
    tick();
    chk("idex_lat_t", W'(idex_pred_taken), 32'h1);
    chk("idex_lat_a", idex_pred_addr, 32'h200);
    tick();
    chk("exmem_lat_t", W'(exmem_pred_taken), 32'h1);
    chk("exmem_lat_a", exmem_pred_addr, 32'h200);

    // Counter walk from 2: down to 0 (saturating), up to 3 (saturating).
    upd_step(32'h100, 1'b0, 32'h0);     chk_pred("ctr1", 32'h100, 1'b0, 32'h104);
    upd_step(32'h100, 1'b0, 32'h0);     chk_pred("ctr0", 32'h100, 1'b0, 32'h104);
    upd_step(32'h100, 1'b0, 32'h0);     chk_pred("ctr0_sat", 32'h100, 1'b0, 32'h104);
    upd_step(32'h100, 1'b1, 32'h200);   chk_pred("ctr_up1", 32'h100, 1'b0, 32'h104);
    upd_step(32'h100, 1'b1, 32'h200);   chk_pred("ctr_up2", 32'h100, 1'b1, 32'h200);
    upd_step(32'h100, 1'b1, 32'h200);
    upd_step(32'h100, 1'b1, 32'h200);
    upd_step(32'h100, 1'b1, 32'h220);   chk_pred("tgt_upd", 32'h100, 1'b1, 32'h220);
    upd_step(32'h100, 1'b1, 32'h220);
    upd_step(32'h100, 1'b0, 32'h0);     chk_pred("ctr3_sat", 32'h100, 1'b1, 32'h220);
    upd_step(32'h100, 1'b0, 32'h0);     chk_pred("ctr3_dn", 32'h100, 1'b0, 32'h104);

    // Alias on index 0: 0x140 evicts 0x100; a not-taken miss changes nothing.
    upd_step(32'h140, 1'b1, 32'h300);
    chk_pred("alias_old", 32'h100, 1'b0, 32'h104);
    chk_pred("alias_new", 32'h140, 1'b1, 32'h300);
    upd_step(32'h180, 1'b0, 32'h0);
    chk_pred("nt_miss_keep", 32'h140, 1'b1, 32'h300);
    chk_pred("nt_miss_noalloc", 32'h180, 1'b0, 32'h184);
    chk_pred("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Stall holds IF/ID while ID/EX keeps loading it.
    if_pc = 32'h140;
    tick();
    if_pc = 32'h500; id_stall = 1'b1;
    tick();
    chk("stall_idex_a", idex_pred_addr, 32'h300);
    tick();
    id_stall = 1'b0;
    tick();
    chk("stall_hold_t", W'(idex_pred_taken), 32'h1);
    chk("stall_hold_a", idex_pred_addr, 32'h300);
    tick();
    chk("unstall_t", W'(idex_pred_taken), '0);
    chk("unstall_a", idex_pred_addr, 32'h504);

    // Bubble clears ID/EX for one edge; it then reaches EX/MEM.
    if_pc = 32'h140;
    tick();
    id_stall = 1'b1; id_ex_bubble = 1'b1;
    tick();
    chk("bubble_t", W'(idex_pred_taken), '0);
    chk("bubble_a", idex_pred_addr, '0);
    id_stall = 1'b0; id_ex_bubble = 1'b0;
    tick();
    chk("bubble_exmem_a", exmem_pred_addr, '0);
    chk("bubble_after_a", idex_pred_addr, 32'h300);

    // Flush wins over stall.
    pc_flush = 1'b1; id_stall = 1'b1;
    tick();
    pc_flush = 1'b0; id_stall = 1'b0; if_pc = 32'h500;
    tick();
    chk("flush_t", W'(idex_pred_taken), '0);
    chk("flush_a", idex_pred_addr, '0);

    // Reset mid-operation overrides a simultaneous update and stall.
    upd_step(32'h604, 1'b1, 32'h700);
    upd_step(32'h608, 1'b1, 32'h800);
    chk_pred("pre_rst", 32'h604, 1'b1, 32'h700);
    if_pc = 32'h140;
    tick(); tick(); tick();
    rst = 1'b1; id_stall = 1'b1;
    upd = 1'b1; add_else_minus = 1'b1; upd_src_pc = 32'h60C; upd_target = 32'h900;
    tick();
    rst = 1'b0; id_stall = 1'b0; upd = 1'b0;
    chk("post_rst_idex_t", W'(idex_pred_taken), '0);
    chk("post_rst_idex_a", idex_pred_addr, '0);
    chk("post_rst_exmem_t", W'(exmem_pred_taken), '0);
    chk("post_rst_exmem_a", exmem_pred_addr, '0);
    chk_pred("post_rst_604", 32'h604, 1'b0, 32'h608);
    chk_pred("post_rst_608", 32'h608, 1'b0, 32'h60C);
    chk_pred("post_rst_60c", 32'h60C, 1'b0, 32'h610);
    chk_pred("post_rst_140", 32'h140, 1'b0, 32'h144);
    tick();
    chk("post_rst_ifid", idex_pred_addr, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter W, default 32, datapath/PC width.
REQ-002 SHALL have parameter ENTRIES, default 16, BTB depth, power of two >= 2; IDX = log2(ENTRIES).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 if_pc  input  W  fetch-stage PC to predict.
REQ-006 pc_flush  input  1  clear IF/ID prediction register.
REQ-007 id_stall  input  1  hold IF/ID prediction register.
REQ-008 id_ex_bubble  input  1  clear ID/EX prediction register.
REQ-009 upd  input  1  resolved jump/branch update strobe.
REQ-010 add_else_minus  input  1  resolved outcome: 1 taken, 0 not taken.
REQ-011 upd_src_pc  input  W  PC of resolved instruction.
REQ-012 upd_target  input  W  resolved target; meaningful only when add_else_minus=1.
REQ-013 if_pred_taken  output  1  fetch prediction (combinational).
REQ-014 if_pred_addr  output  W  next fetch address (combinational).
REQ-015 idex_pred_taken, idex_pred_addr  output  1/W  prediction travelling with ID/EX instruction.
REQ-016 exmem_pred_taken, exmem_pred_addr  output  1/W  prediction travelling with EX/MEM instruction.

Function
REQ-017 BTB SHALL be direct-mapped, ENTRIES x {valid, tag, target[W], ctr[2]}; index = pc[IDX+1:2], tag = pc[W-1:IDX+2].
REQ-018 Lookup hit = valid && tag match on if_pc; if_pred_taken = hit && ctr[1].
REQ-019 if_pred_addr = target when if_pred_taken, else if_pc + 4 (mod 2^W).
REQ-020 Lookup SHALL read pre-update state; an update in cycle N is visible to lookups from cycle N+1.
REQ-021 upd=1, hit, taken: ctr SHALL increment saturating at 3; target <= upd_target.
REQ-022 upd=1, hit, not taken: ctr SHALL decrement saturating at 0; valid, tag, target unchanged.
REQ-023 upd=1, miss, taken: entry SHALL be allocated/overwritten: valid=1, tag, target=upd_target, ctr=2'b10.
REQ-024 upd=1, miss, not taken: no BTB change.
REQ-025 upd=0: no BTB change.
REQ-026 Prediction pipeline: IF/ID reg <= {if_pred_taken, if_pred_addr}; ID/EX reg <= IF/ID reg; EX/MEM reg <= ID/EX reg; every clock.
REQ-027 IF/ID priority: pc_flush clears to {0,0} over id_stall; id_stall holds; else load.
REQ-028 ID/EX: id_ex_bubble clears to {0,0}; otherwise loads IF/ID (including while id_stall, so the bubble propagates).
REQ-029 EX/MEM SHALL never stall; it loads ID/EX every cycle.
REQ-030 idex_*/exmem_* outputs SHALL be the ID/EX and EX/MEM registers directly (1-cycle registered latency per stage).

Reset
REQ-031 rst=1 at a clock edge SHALL clear all valid bits, all ctr to 0, all targets/tags to 0, and all pipeline registers to {0,0}; applies mid-operation.
REQ-032 rst SHALL override upd, pc_flush, id_stall and id_ex_bubble in the same cycle.
REQ-033 After reset, if_pred_taken=0 and if_pred_addr=if_pc+4 for every if_pc.

Verification
REQ-034 Post-reset, if_pc=0x100 -> if_pred_taken=0, if_pred_addr=0x104; idex/exmem outputs 0.
REQ-035 upd=1, add_else_minus=1, upd_src_pc=0x100, upd_target=0x200 -> same cycle if_pc=0x100 still predicts 0x104; next cycle taken=1, addr=0x200; two cycles later idex_pred_addr=0x200, three cycles later exmem_pred_addr=0x200.
REQ-036 From ctr=2 at 0x100: two not-taken updates -> ctr=0, predict 0x104; third not-taken keeps 0; two taken -> ctr=2, predict target; four taken -> ctr saturates at 3.
REQ-037 Alias (ENTRIES=16): 0x100 allocated, then taken update 0x140 target 0x300 -> 0x100 predicts not taken/0x104, 0x140 predicts 0x300.
REQ-038 Pipeline controls: id_stall=1 for 2 cycles holds IF/ID and inserts {0,0} into ID/EX only when id_ex_bubble=1; pc_flush with id_stall clears IF/ID; id_ex_bubble clears ID/EX next edge.
REQ-039 rst asserted one cycle after several allocations -> all subsequent lookups not taken, pipeline outputs 0.
